// File: rtl/decode_queue.sv
// decode_queue: MIPS32 decode queue between fetch and issue.
// Accepts up to IN_W instructions per cycle, decodes destination register and
// dispatch class at enqueue, and holds entries in a DEPTH-entry circular buffer.
// Issue sees the OUT_W oldest entries and retires an in-order prefix via out_pop.
// Ports:
//   clk, resetn (async active-low), flush (drop all entries)
//   in_valid/in_inst/in_pc   fetch lanes, valid lanes contiguous from lane 0
//   in_ready                 at least IN_W free slots
//   out_valid/out_inst/out_pc/out_rs/out_rt/out_rd/out_sa/out_imm/out_index
//   out_dest/out_cls         per issue lane, lane 0 oldest; cls = {is_st,is_ld,is_br}
//   out_pop                  entries retired this cycle
//   count                    occupied entries
module decode_queue #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_valid,
    input  logic [32*IN_W-1:0]           in_inst,
    input  logic [32*IN_W-1:0]           in_pc,
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_valid,
    output logic [32*OUT_W-1:0]          out_inst,
    output logic [32*OUT_W-1:0]          out_pc,
    output logic [5*OUT_W-1:0]           out_rs,
    output logic [5*OUT_W-1:0]           out_rt,
    output logic [5*OUT_W-1:0]           out_rd,
    output logic [5*OUT_W-1:0]           out_sa,
    output logic [16*OUT_W-1:0]          out_imm,
    output logic [26*OUT_W-1:0]          out_index,
    output logic [5*OUT_W-1:0]           out_dest,
    output logic [3*OUT_W-1:0]           out_cls,
    input  logic [$clog2(OUT_W+1)-1:0]   out_pop,
    output logic [CW-1:0]                count
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [4:0]    dest_q [DEPTH];
    logic [2:0]    cls_q  [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, push_n, pop_n;
    logic          push_en;
    logic [7:0]    dec [IN_W];

    // Returns {cls, dest}
    function automatic logic [7:0] decode(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        logic [2:0] cls;
        logic [4:0] dest;
        cls  = 3'b000;
        dest = 5'd0;
        if (op == 6'h00) begin
            dest = rd;
            if (fn == 6'h08) begin
                cls  = 3'b001;
                dest = 5'd0;
            end else if (fn == 6'h09) begin
                cls = 3'b001;
            end else if (fn == 6'h0C || fn == 6'h0D || (fn >= 6'h18 && fn <= 6'h1B)) begin
                dest = 5'd0;
            end
        end else if (op == 6'h01) begin
            cls  = 3'b001;
            dest = (rt == 5'h10 || rt == 5'h11) ? 5'd31 : 5'd0;
        end else if (op == 6'h02 || (op >= 6'h04 && op <= 6'h07)) begin
            cls = 3'b001;
        end else if (op == 6'h03) begin
            cls  = 3'b001;
            dest = 5'd31;
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            dest = rt;
        end else if (op >= 6'h20 && op <= 6'h26) begin
            cls  = 3'b010;
            dest = rt;
        end else if (op >= 6'h28 && op <= 6'h2E) begin
            cls = 3'b100;
        end else if (op == 6'h10) begin
            dest = (rs == 5'd0) ? rt : 5'd0;
        end
        return {cls, dest};
    endfunction

    assign in_ready = count_q <= CW'(DEPTH - IN_W);
    assign push_en  = in_ready & in_valid[0];
    assign count    = count_q;

    always_comb begin
        push_n = '0;
        for (int i = 0; i < IN_W; i++) begin
            push_n = push_n + CW'(in_valid[i]);
            dec[i] = decode(in_inst[32*i+26 +: 6], in_inst[32*i +: 6], in_inst[32*i+21 +: 5],
                            in_inst[32*i+16 +: 5], in_inst[32*i+11 +: 5]);
        end
        if (!push_en) push_n = '0;
        // Over-popping is illegal; clamp so state stays consistent anyway.
        pop_n   = (CW'(out_pop) > count_q) ? count_q : CW'(out_pop);
        head_d  = flush ? '0 : head_q + PW'(pop_n);
        tail_d  = flush ? '0 : tail_q + PW'(push_n);
        count_d = flush ? '0 : count_q + push_n - pop_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                inst_q[j] <= '0;
                pc_q[j]   <= '0;
                dest_q[j] <= '0;
                cls_q[j]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < IN_W; i++) begin
                if (push_en && in_valid[i]) begin
                    inst_q[tail_q + PW'(i)] <= in_inst[32*i +: 32];
                    pc_q[tail_q + PW'(i)]   <= in_pc[32*i +: 32];
                    dest_q[tail_q + PW'(i)] <= dec[i][4:0];
                    cls_q[tail_q + PW'(i)]  <= dec[i][7:5];
                end
            end
        end
    end

    for (genvar k = 0; k < OUT_W; k++) begin : g_out
        logic [PW-1:0] idx;
        assign idx                   = head_q + PW'(k);
        assign out_valid[k]          = count_q > CW'(k);
        assign out_inst[32*k +: 32]  = inst_q[idx];
        assign out_pc[32*k +: 32]    = pc_q[idx];
        assign out_rs[5*k +: 5]      = inst_q[idx][25:21];
        assign out_rt[5*k +: 5]      = inst_q[idx][20:16];
        assign out_rd[5*k +: 5]      = inst_q[idx][15:11];
        assign out_sa[5*k +: 5]      = inst_q[idx][10:6];
        assign out_imm[16*k +: 16]   = inst_q[idx][15:0];
        assign out_index[26*k +: 26] = inst_q[idx][25:0];
        assign out_dest[5*k +: 5]    = dest_q[idx];
        assign out_cls[3*k +: 3]     = cls_q[idx];
    end

    a_pop_legal: assert property (@(posedge clk) disable iff (!resetn) CW'(out_pop) <= count_q);

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed vectors for decode_queue with hand-computed expectations.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst, in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst, out_pc;
    logic [9:0]  out_rs, out_rt, out_rd, out_sa, out_dest;
    logic [31:0] out_imm;
    logic [51:0] out_index;
    logic [5:0]  out_cls;
    logic [1:0]  out_pop;
    logic [3:0]  count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] ADDU   = 32'h0022_1821;
    localparam logic [31:0] LW     = 32'h8CA4_0008;
    localparam logic [31:0] JAL    = 32'h0C00_0040;
    localparam logic [31:0] SW     = 32'hAFA2_0000;
    localparam logic [31:0] JR     = 32'h03E0_0008;
    localparam logic [31:0] BGEZAL = 32'h0411_0010;
    localparam logic [31:0] MFC0   = 32'h4007_0000;
    localparam logic [31:0] MULT   = 32'h0043_2818;

    decode_queue dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
        .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_sa(out_sa), .out_imm(out_imm), .out_index(out_index),
        .out_dest(out_dest), .out_cls(out_cls), .out_pop(out_pop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [1:0] pop, input logic fl);
        in_valid = v;
        in_inst  = {i1, i0};
        in_pc    = {p1, p0};
        out_pop  = pop;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = '0;
        out_pop  = '0;
        flush    = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        resetn = 1'b0; flush = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0; out_pop = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_inst", out_inst, 64'd0);

        drive(2'b11, ADDU, 32'h100, LW, 32'h104, 2'd0, 1'b0);
        chk("p2_valid", 64'(out_valid), 64'b11);
        chk("p2_dest", 64'(out_dest), {54'd0, 5'd4, 5'd3});
        chk("p2_cls1", 64'(out_cls[5:3]), 64'b010);
        chk("p2_cls0", 64'(out_cls[2:0]), 64'b000);
        chk("p2_pc0", 64'(out_pc[31:0]), 64'h100);
        chk("p2_pc1", 64'(out_pc[63:32]), 64'h104);
        chk("p2_rsrt", 64'({out_rs[4:0], out_rt[4:0]}), {54'd0, 5'd1, 5'd2});
        chk("p2_imm1", 64'(out_imm[31:16]), 64'd8);

        for (int i = 0; i < 3; i++)
            drive(2'b11, ADDU, 32'h108 + 32'(8*i), ADDU, 32'h10C + 32'(8*i), 2'd0, 1'b0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(in_ready), 64'd0);
        drive(2'b11, LW, 32'h900, LW, 32'h904, 2'd0, 1'b0);
        drive(2'b11, LW, 32'h900, LW, 32'h904, 2'd0, 1'b0);
        chk("full_ign_count", 64'(count), 64'd8);
        chk("full_ign_pc", out_pc, {32'h104, 32'h100});
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
        chk("pop_count", 64'(count), 64'd6);
        chk("pop_ready", 64'(in_ready), 64'd1);
        chk("pop_pc", 64'(out_pc[31:0]), 64'h108);
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
        chk("drain_pc1", 64'(out_pc[31:0]), 64'h110);
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
        chk("drain_pc2", 64'(out_pc[31:0]), 64'h118);
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        exp_pc = 32'h2000;
        drive(2'b11, ADDU, exp_pc, ADDU, exp_pc + 4, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_pc", out_pc, {exp_pc + 32'd4, exp_pc});
            chk("wrap_count", 64'(count), 64'd2);
            drive(2'b11, ADDU, exp_pc + 8, ADDU, exp_pc + 12, 2'd2, 1'b0);
            exp_pc = exp_pc + 8;
        end
        chk("wrap_last", out_pc, {exp_pc + 32'd4, exp_pc});
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
        chk("wrap_empty", 64'(count), 64'd0);

        drive(2'b11, ADDU, 32'h10, ADDU, 32'h14, 2'd0, 1'b0);
        drive(2'b11, ADDU, 32'h18, ADDU, 32'h1C, 2'd0, 1'b0);
        chk("fl_pre", 64'(count), 64'd4);
        drive(2'b11, LW, 32'h20, LW, 32'h24, 2'd1, 1'b1);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        drive(2'b01, ADDU, 32'h3000, 0, 0, 2'd0, 1'b0);
        chk("fl_after_pc", 64'(out_pc[31:0]), 64'h3000);
        chk("fl_after_valid", 64'(out_valid), 64'b01);
        drive(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);

        drive(2'b11, JAL, 32'h400, SW, 32'h404, 2'd0, 1'b0);
        chk("jal_dest", 64'(out_dest[4:0]), 64'd31);
        chk("jal_cls", 64'(out_cls[2:0]), 64'b001);
        chk("sw_dest", 64'(out_dest[9:5]), 64'd0);
        chk("sw_cls", 64'(out_cls[5:3]), 64'b100);
        drive(2'b11, JR, 32'h408, BGEZAL, 32'h40C, 2'd2, 1'b0);
        chk("jr_dest", 64'(out_dest[4:0]), 64'd0);
        chk("jr_cls", 64'(out_cls[2:0]), 64'b001);
        chk("bgezal_dest", 64'(out_dest[9:5]), 64'd31);
        chk("bgezal_cls", 64'(out_cls[5:3]), 64'b001);
        drive(2'b11, MFC0, 32'h410, MULT, 32'h414, 2'd2, 1'b0);
        chk("mfc0_dest", 64'(out_dest[4:0]), 64'd7);
        chk("mult_dest", 64'(out_dest[9:5]), 64'd0);
        chk("mfc0_mult_cls", 64'(out_cls), 64'd0);
        drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);

        drive(2'b11, ADDU, 32'h500, ADDU, 32'h504, 2'd0, 1'b0);
        drive(2'b11, ADDU, 32'h508, ADDU, 32'h50C, 2'd0, 1'b0);
        drive(2'b01, ADDU, 32'h510, 0, 0, 2'd0, 1'b0);
        chk("mid_pre", 64'(count), 64'd5);
        resetn = 1'b0;
        #1;
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        chk("mid_pc", out_pc, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
